bank_rd_arb: RTL

BANK_RD_ARB -- requirements
Module: bank_rd_arb

---
 rtl/bank_rd_arb.sv | 92 +++++++++
 1 files changed

// File: rtl/bank_rd_arb.sv
// Per-bank round-robin read-port arbiter for a banked register file.
// Registered grants, acks and bad-bank errors, one cycle after the request.
module bank_rd_arb #(
    parameter int NUM_BANKS    = 3,
    parameter int SIZE_BANKI   = 32,
    parameter int NUM_RD_PORTS = 3,
    localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int LOG_NUM = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_RD_PORTS-1:0]                req,
    input  logic [NUM_RD_PORTS-1:0][BANK_W-1:0]    req_bank,
    input  logic [NUM_BANKS-1:0]                   bank_stall,
    output logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0] gnt,
    output logic [NUM_RD_PORTS-1:0]                ack,
    output logic [NUM_RD_PORTS-1:0]                err
);

    if (SIZE_BANKI < 1 || NUM_BANKS < 1 || NUM_RD_PORTS < 1) begin : g_param_chk
        $error("bank_rd_arb: parameters must be positive");
    end

    logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0] gnt_q, gnt_d;
    logic [NUM_BANKS-1:0][LOG_NUM-1:0]      ptr_q, ptr_d;
    logic [NUM_RD_PORTS-1:0]                ack_q, ack_d;
    logic [NUM_RD_PORTS-1:0]                err_q, err_d;
    logic [NUM_RD_PORTS-1:0]                elig;
    logic                                   found;

    always_comb begin
        gnt_d = '0;
        ack_d = '0;
        err_d = '0;
        ptr_d = ptr_q;
        elig  = '0;
        found = 1'b0;

        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (req[p] && !err_q[p] &&
                ({1'b0, req_bank[p]} >= (BANK_W+1)'(NUM_BANKS))) begin
                err_d[p] = 1'b1;
            end
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            found = 1'b0;
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                elig[p] = req[p] && !ack_q[p] && !bank_stall[b] &&
                          (req_bank[p] == BANK_W'(b));
            end
            // Rotated search: first pass covers ptr..N-1, second wraps to 0.
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (!found && elig[p] && (LOG_NUM'(p) >= ptr_q[b])) begin
                    found       = 1'b1;
                    gnt_d[b][p] = 1'b1;
                    ptr_d[b]    = (p == NUM_RD_PORTS - 1) ? '0 : LOG_NUM'(p + 1);
                end
            end
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (!found && elig[p]) begin
                    found       = 1'b1;
                    gnt_d[b][p] = 1'b1;
                    ptr_d[b]    = (p == NUM_RD_PORTS - 1) ? '0 : LOG_NUM'(p + 1);
                end
            end
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            ack_d = ack_d | gnt_d[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= '0;
            ptr_q <= '0;
            ack_q <= '0;
            err_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign gnt = gnt_q;
    assign ack = ack_q;
    assign err = err_q;

endmodule
